alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
// - Parametrised, registered successor of the 16-bit combinational datapath ALU.
// - Adds a valid/ready handshake on input and output, carry and overflow flags,
//   and an iterative signed multiply (opc 7).
// - Sits between the operand register file and the writeback stage; one op in flight.
// PARAMETERS
// - WIDTH   16  operand/result width in bits (>=4); operands are two's complement
// - MUL_EN  1   1: opc 7 is an iterative multiply; 0: opc 7 returns 0 with latency 1
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous, active-low reset
// - in_valid   in   1      operands/opcode valid
// - in_ready   out  1      block accepts an op this cycle
// - inM, inN   in   WIDTH  signed operands
// - inC        in   1      carry-in (opc 0 only)
// - opc        in   3      operation select
// - out_valid  out  1      result/flags valid
// - out_ready  in   1      consumer takes the result this cycle
// - outF       out  WIDTH  signed result
// - neg, zer   out  1      outF[WIDTH-1]; outF==0
// - cry, ovf   out  1      unsigned carry-out; signed overflow
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; outF, neg, zer, cry, ovf, out_valid = 0;
//   multiply counter and accumulators cleared. Reset mid-multiply aborts the op; no output.
// - Accept: in_valid & in_ready at a clock edge. in_ready = IDLE | (DONE & out_ready).
// - States: IDLE -accept, opc!=7 or MUL_EN=0-> DONE; IDLE -accept, opc 7-> BUSY;
//   BUSY -counter hits 0-> DONE; DONE -out_ready & !in_valid-> IDLE;
//   DONE -out_ready & in_valid-> DONE or BUSY (back-to-back, throughput 1 for simple ops).
// - Latency: simple ops, out_valid high the cycle after accept;
//   multiply, out_valid high WIDTH cycles after accept. in_ready = 0 throughout BUSY.
// - DONE with out_ready=0: outF and all flags held stable; in_ready=0.
// - Operand/opcode are captured at accept; later input changes are ignored.
// - Ops (arithmetic in WIDTH+1 bits; outF = low WIDTH bits):
//   0 M+N+C; cry = bit WIDTH unsigned; ovf = signed overflow
//   1 M+(N>>>1), arithmetic shift; cry/ovf as opc 0
//   2 signed max(M,N); cry=ovf=0
//   3 3*M = (M<<1)+M; cry = unsigned sum >= 2^WIDTH; ovf = true value outside signed range
//   4 M&N   5 M|N   6 ~M; cry=ovf=0
//   7 signed M*N; outF = low WIDTH bits of the product; cry=0; ovf = upper WIDTH bits
//     are not the sign extension of outF. WIDTH iterations of shift-add with sign correction.
// - neg/zer always derived from the registered outF, including opc 2/4/5/6.
// - out_valid drops the cycle after out_ready unless a new result is produced that edge.
// STRUCTURE
// - Shared package alu_pkg: opcode localparams OP_ADD..OP_MUL (3-bit); state enum IDLE/BUSY/DONE.
// - Sub-module alu_mul_iter (WIDTH): start/done, signed shift-add multiplier, returns 2*WIDTH product.
// - Top-level: handshake FSM, single-cycle combinational op unit, output/flag registers.
// TESTING (WIDTH=16)
// - opc0 M=0x7FFF N=0 C=1 -> outF=0x8000 neg=1 ovf=1 cry=0 zer=0; out_valid 1 cycle after accept
// - opc2 M=0xFFFB(-5) N=0x0003 -> outF=0x0003 neg=0; opc1 M=1 N=0xFFFC -> outF=0xFFFF neg=1
// - opc7 M=0xFFFD(-3) N=7 -> outF=0xFFEB ovf=0, out_valid exactly 16 cycles after accept,
//   in_ready=0 meanwhile; opc7 M=0x0100 N=0x0100 -> outF=0 zer=1 ovf=1
// - out_ready=0 for 5 cycles in DONE -> outF/flags stable, in_ready=0; then opc4/opc5/opc6
//   back-to-back with out_ready=1 -> one result per cycle, in order
// - rst_n low at cycle 5 of a multiply -> all outputs 0 immediately (async); after release
//   in_ready=1, no stale result ever appears
// - opc6 M=0xFFFF -> outF=0 zer=1; opc0 M=0xFFFF N=1 C=0 -> outF=0 cry=1 ovf=0 zer=1

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and handshake states shared by the sequential ALU.
package alu_pkg;
    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_ADDSH = 3'd1;
    localparam logic [2:0] OP_MAX   = 3'd2;
    localparam logic [2:0] OP_TRI   = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_OR    = 3'd5;
    localparam logic [2:0] OP_NOT   = 3'd6;
    localparam logic [2:0] OP_MUL   = 3'd7;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: signed shift-add multiplier, one partial product per clock.
// Step 0 runs on the start edge; o_done flags the cycle whose step is the last.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_m,
    input  logic [WIDTH-1:0]   i_n,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_prod
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH:0]   r_a, w_a_in, w_pp, w_sum, w_a_nx;
    logic [WIDTH-1:0] r_q, r_m, w_q_in, w_m_in, w_q_nx;
    logic [CW-1:0]    r_cnt;
    assign o_done = !i_start && r_cnt == CW'(1);
    assign o_prod = {w_a_nx[WIDTH-1:0], w_q_nx};
    // The multiplier's sign bit carries weight -2^(WIDTH-1), so the last partial product is subtracted.
    always_comb begin
        w_a_in = i_start ? '0 : r_a;
        w_q_in = i_start ? i_n : r_q;
        w_m_in = i_start ? i_m : r_m;
        w_pp   = w_q_in[0] ? {w_m_in[WIDTH-1], w_m_in} : '0;
        w_sum  = o_done ? w_a_in - w_pp : w_a_in + w_pp;
        w_a_nx = {w_sum[WIDTH], w_sum[WIDTH:1]};
        w_q_nx = {w_sum[0], w_q_in[WIDTH-1:1]};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_a   <= w_a_nx;
            r_q   <= w_q_nx;
            r_m   <= i_m;
            r_cnt <= CW'(WIDTH - 1);
        end else if (r_cnt != '0) begin
            r_a   <= w_a_nx;
            r_q   <= w_q_nx;
            r_cnt <= r_cnt - CW'(1);
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, carry/overflow flags
// and an optional iterative signed multiply; one op in flight.
module alu_seq import alu_pkg::*; #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inM,
    input  logic [WIDTH-1:0] inN,
    input  logic             inC,
    input  logic [2:0]       opc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] outF,
    output logic             neg,
    output logic             zer,
    output logic             cry,
    output logic             ovf
);
    state_t             r_state, w_state_nx;
    logic [WIDTH-1:0]   r_f, w_f, w_b, w_res;
    logic               r_neg, r_zer, r_cry, r_ovf;
    logic               w_cry, w_ovf, w_res_cry, w_res_ovf, w_mov;
    logic               w_acc, w_mul, w_mdone, w_load;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH+1:0]   w_tri;
    logic [2:0]         w_th;
    logic [2*WIDTH-1:0] w_prod;
    assign in_ready  = r_state == IDLE || (r_state == DONE && out_ready);
    assign out_valid = r_state == DONE;
    assign w_acc     = in_valid && in_ready;
    assign w_mul     = MUL_EN && opc == OP_MUL;
    assign w_load    = (w_acc && !w_mul) || (r_state == BUSY && w_mdone);
    assign {outF, neg, zer, cry, ovf} = {r_f, r_neg, r_zer, r_cry, r_ovf};
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_acc && w_mul),
        .i_m     (inM),
        .i_n     (inN),
        .o_done  (w_mdone),
        .o_prod  (w_prod)
    );
    assign w_b   = opc == OP_ADDSH ? {inN[WIDTH-1], inN[WIDTH-1:1]} : inN;
    assign w_sum = {1'b0, inM} + {1'b0, w_b} + (WIDTH+1)'(inC && opc == OP_ADD);
    assign w_tri = {2'b00, inM} + {1'b0, inM, 1'b0};
    // Top bits of the signed 3*M: remove the 3*2^WIDTH the unsigned view adds for negative M.
    assign w_th  = w_tri[WIDTH+1:WIDTH-1] - (inM[WIDTH-1] ? 3'd6 : 3'd0);
    assign w_mov = w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}};
    always_comb begin
        w_f   = '0;
        w_cry = 1'b0;
        w_ovf = 1'b0;
        case (opc)
            OP_ADD, OP_ADDSH: begin
                w_f   = w_sum[WIDTH-1:0];
                w_cry = w_sum[WIDTH];
                w_ovf = inM[WIDTH-1] == w_b[WIDTH-1] && w_sum[WIDTH-1] != inM[WIDTH-1];
            end
            OP_MAX: w_f = $signed(inM) > $signed(inN) ? inM : inN;
            OP_TRI: begin
                w_f   = w_tri[WIDTH-1:0];
                w_cry = |w_tri[WIDTH+1:WIDTH];
                w_ovf = w_th != 3'b000 && w_th != 3'b111;
            end
            OP_AND: w_f = inM & inN;
            OP_OR:  w_f = inM | inN;
            OP_NOT: w_f = ~inM;
            default: ;
        endcase
    end
    assign w_res     = r_state == BUSY ? w_prod[WIDTH-1:0] : w_f;
    assign w_res_cry = r_state == BUSY ? 1'b0 : w_cry;
    assign w_res_ovf = r_state == BUSY ? w_mov : w_ovf;
    always_comb begin
        w_state_nx = r_state;
        if (w_acc)
            w_state_nx = w_mul ? BUSY : DONE;
        else if (r_state == BUSY && w_mdone)
            w_state_nx = DONE;
        else if (r_state == DONE && out_ready)
            w_state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f   <= '0;
            r_neg <= 1'b0;
            r_zer <= 1'b0;
            r_cry <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_load) begin
            r_f   <= w_res;
            r_neg <= w_res[WIDTH-1];
            r_zer <= w_res == '0;
            r_cry <= w_res_cry;
            r_ovf <= w_res_ovf;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors; expected results queued at issue, checked by a
// separate monitor on every output handshake.
module tb_alu_seq;
    typedef struct packed {
        logic [15:0] f;
        logic        neg, zer, cry, ovf;
    } res_t;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, inC = 1'b0;
    logic [15:0] inM = '0, inN = '0;
    logic [2:0]  opc = '0;
    logic        in_ready, out_valid, neg, zer, cry, ovf;
    logic [15:0] outF;
    int          n_run = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
    res_t        q[$];

    alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inM       (inM),
        .inN       (inN),
        .inC       (inC),
        .opc       (opc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outF      (outF),
        .neg       (neg),
        .zer       (zer),
        .cry       (cry),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic res_t mk(input logic [15:0] f, input logic c, input logic o);
        return '{f: f, neg: f[15], zer: f == 16'h0, cry: c, ovf: o};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_result: got %h expected none", outF);
            end else begin
                chk("result", {12'h0, outF, neg, zer, cry, ovf}, {12'h0, q.pop_front()});
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [15:0] m, input logic [15:0] n,
                         input logic c, input res_t e);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_run++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        opc = o; inM = m; inN = n; inC = c; in_valid = 1'b1;
        q.push_back(e);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0; inM = ~m; inN = ~n; inC = ~c; opc = ~o;
    endtask

    task automatic wait_out(input int lat, input string nm);
        int t = 0, rdy = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin
            rdy += int'(in_ready);
            @(negedge clk);
            t++;
        end
        chk(nm, cyc - acc_cyc + 1, lat);
        chk({nm, "_in_ready"}, rdy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int a, t, stale;
        #1;
        chk("reset_outputs", {26'h0, outF != 0, neg, zer, cry, ovf, out_valid}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);

        issue(3'd0, 16'h7FFF, 16'h0000, 1'b1, mk(16'h8000, 1'b0, 1'b1));
        wait_out(1, "lat_add");
        issue(3'd2, 16'hFFFB, 16'h0003, 1'b0, mk(16'h0003, 1'b0, 1'b0));
        issue(3'd1, 16'h0001, 16'hFFFC, 1'b0, mk(16'hFFFF, 1'b0, 1'b0));
        issue(3'd7, 16'hFFFD, 16'h0007, 1'b0, mk(16'hFFEB, 1'b0, 1'b0));
        wait_out(16, "lat_mul");
        issue(3'd7, 16'h0100, 16'h0100, 1'b0, mk(16'h0000, 1'b0, 1'b1));
        wait_out(16, "lat_mul_ovf");

        out_ready = 1'b0;
        issue(3'd0, 16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        repeat (5) begin
            @(negedge clk);
            chk("hold", {10'h0, outF, neg, zer, cry, ovf, out_valid, in_ready},
                {10'h0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        issue(3'd4, 16'hF0F0, 16'hFF00, 1'b0, mk(16'hF000, 1'b0, 1'b0));
        a = acc_cyc;
        issue(3'd5, 16'h00F0, 16'h0F00, 1'b0, mk(16'h0FF0, 1'b0, 1'b0));
        chk("b2b_1", acc_cyc - a, 1);
        a = acc_cyc;
        issue(3'd6, 16'hFFFF, 16'h1234, 1'b0, mk(16'h0000, 1'b0, 1'b0));
        chk("b2b_2", acc_cyc - a, 1);

        issue(3'd3, 16'h4000, 16'h0000, 1'b0, mk(16'hC000, 1'b0, 1'b1));
        issue(3'd3, 16'hFFFF, 16'h0000, 1'b0, mk(16'hFFFD, 1'b1, 1'b0));
        issue(3'd0, 16'h1234, 16'h0001, 1'b1, mk(16'h1236, 1'b0, 1'b0));

        issue(3'd1, 16'h0001, 16'hFFFC, 1'b0, mk(16'hFFFF, 1'b0, 1'b0));
        wait_out(1, "lat_pre_reset");
        issue(3'd7, 16'h0005, 16'h0009, 1'b0, mk(16'h002D, 1'b0, 1'b0));
        repeat (5) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {26'h0, outF != 0, neg, zer, cry, ovf, out_valid}, 0);
        void'(q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);
        stale = 0;
        repeat (30) begin
            @(negedge clk);
            stale += int'(out_valid);
        end
        chk("no_stale", stale, 0);

        issue(3'd6, 16'h0000, 16'h0000, 1'b0, mk(16'hFFFF, 1'b0, 1'b0));
        issue(3'd7, 16'hFFFF, 16'hFFFF, 1'b0, mk(16'h0001, 1'b0, 1'b0));
        wait_out(16, "lat_mul_neg");

        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
